// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the stage_ctrl multi-cycle sequencer: state encoding,
// the reset instruction and the wait-counter width.
package stage_ctrl_pkg;

  localparam int unsigned STG_STATE_WIDTH = 3;
  localparam int unsigned STG_TO_WIDTH    = 16;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;

  typedef enum logic [STG_STATE_WIDTH-1:0] {
    STG_IDLE       = 3'd0,
    STG_FETCH_REQ  = 3'd1,
    STG_FETCH_WAIT = 3'd2,
    STG_EXEC       = 3'd3,
    STG_MEM_REQ    = 3'd4,
    STG_MEM_WAIT   = 3'd5,
    STG_WB         = 3'd6,
    STG_HALT       = 3'd7
  } stg_state_e;

endpackage

// File: rtl/stage_ctrl_timeout.sv
// stage_timeout: saturating wait counter for stage_ctrl; expired flags the last
// permitted cycle of a wait state.
module stage_timeout
  import stage_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [STG_TO_WIDTH-1:0] LAST = STG_TO_WIDTH'(LIMIT - 1);

  logic [STG_TO_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of cycles already spent waiting, so reaching LAST
  // means the current cycle is the LIMIT-th one.
  assign expired = inc && (cnt >= LAST);

endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: FETCH -> EXEC -> (MEM) -> WB sequencer with bus timeout halt.
// Optional performance counters are enabled by defining STAGE_CTRL_PERF_CNT_EN.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef STAGE_CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_WIDTH    = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid_o,
  input  logic                  ifu_req_ready_i,
  input  logic                  ifu_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [INST_WIDTH-1:0] inst_o,
  input  logic                  mem_access_i,
  input  logic                  halt_i,
  output logic                  lsu_req_valid_o,
  input  logic                  lsu_req_ready_i,
  input  logic                  lsu_rsp_valid_i,
  output logic                  pc_we_o,
  output logic                  rf_we_en_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  err_o
`ifdef STAGE_CTRL_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] cycle_cnt_o
  , output logic [CNT_WIDTH-1:0] retire_cnt_o
`endif
);

  stg_state_e state, state_next;
  logic       wait_inc, wait_expired;
  logic       load_inst, to_err;

  stage_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_next != state),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  // Handshake success is tested before expiry so a same-edge ready/response wins.
  always_comb begin
    state_next = state;
    wait_inc   = 1'b0;
    load_inst  = 1'b0;
    to_err     = 1'b0;
    unique case (state)
      STG_IDLE: state_next = STG_FETCH_REQ;
      STG_FETCH_REQ: begin
        wait_inc = 1'b1;
        if (ifu_req_ready_i)   state_next = STG_FETCH_WAIT;
        else if (wait_expired) begin state_next = STG_HALT; to_err = 1'b1; end
      end
      STG_FETCH_WAIT: begin
        wait_inc = 1'b1;
        if (ifu_rsp_valid_i) begin
          state_next = STG_EXEC;
          load_inst  = 1'b1;
        end else if (wait_expired) begin
          state_next = STG_HALT;
          to_err     = 1'b1;
        end
      end
      STG_EXEC: begin
        if (halt_i)            state_next = STG_HALT;
        else if (mem_access_i) state_next = STG_MEM_REQ;
        else                   state_next = STG_WB;
      end
      STG_MEM_REQ: begin
        wait_inc = 1'b1;
        if (lsu_req_ready_i)   state_next = STG_MEM_WAIT;
        else if (wait_expired) begin state_next = STG_HALT; to_err = 1'b1; end
      end
      STG_MEM_WAIT: begin
        wait_inc = 1'b1;
        if (lsu_rsp_valid_i)   state_next = STG_WB;
        else if (wait_expired) begin state_next = STG_HALT; to_err = 1'b1; end
      end
      STG_WB:   state_next = STG_FETCH_REQ;
      STG_HALT: state_next = STG_HALT;
      default:  state_next = STG_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= STG_IDLE;
      inst_o <= INST_WIDTH'(NOP_INST);
      err_o  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_inst) inst_o <= inst_i;
      if (to_err)    err_o  <= 1'b1;
    end
  end

  assign ifu_req_valid_o = (state == STG_FETCH_REQ);
  assign lsu_req_valid_o = (state == STG_MEM_REQ);
  assign pc_we_o         = (state == STG_WB);
  assign rf_we_en_o      = (state == STG_WB);
  assign busy_o          = (state != STG_HALT);
  assign halted_o        = (state == STG_HALT);

`ifdef STAGE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (busy_o)            cycle_cnt_o  <= cycle_cnt_o + 1'b1;
      if (state == STG_WB)   retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// Self-checking bench for stage_ctrl: per-cycle vector table with a scoreboard
// queue, plus hand-written halt, timeout, async-reset and counter sequences.
module tb_stage_ctrl;
  import stage_ctrl_pkg::*;

  localparam logic [6:0] O_IDLE  = 7'b0000100;
  localparam logic [6:0] O_FREQ  = 7'b1000100;
  localparam logic [6:0] O_WAIT  = 7'b0000100;
  localparam logic [6:0] O_EXEC  = 7'b0000100;
  localparam logic [6:0] O_MREQ  = 7'b0100100;
  localparam logic [6:0] O_WB    = 7'b0011100;
  localparam logic [6:0] O_HALT  = 7'b0000010;
  localparam logic [6:0] O_HERR  = 7'b0000011;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_8113;
  localparam logic [31:0] I3  = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid_o, ifu_req_ready_i, ifu_rsp_valid_i;
  logic [31:0] inst_i, inst_o;
  logic        mem_access_i, halt_i;
  logic        lsu_req_valid_o, lsu_req_ready_i, lsu_rsp_valid_i;
  logic        pc_we_o, rf_we_en_o, busy_o, halted_o, err_o;
`ifdef STAGE_CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt_o, retire_cnt_o;
`endif

  always #5 clk = ~clk;

  stage_ctrl #(.INST_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu_req_valid_o (ifu_req_valid_o),
    .ifu_req_ready_i (ifu_req_ready_i),
    .ifu_rsp_valid_i (ifu_rsp_valid_i),
    .inst_i          (inst_i),
    .inst_o          (inst_o),
    .mem_access_i    (mem_access_i),
    .halt_i          (halt_i),
    .lsu_req_valid_o (lsu_req_valid_o),
    .lsu_req_ready_i (lsu_req_ready_i),
    .lsu_rsp_valid_i (lsu_rsp_valid_i),
    .pc_we_o         (pc_we_o),
    .rf_we_en_o      (rf_we_en_o),
    .busy_o          (busy_o),
    .halted_o        (halted_o),
    .err_o           (err_o)
`ifdef STAGE_CTRL_PERF_CNT_EN
    , .cycle_cnt_o   (cycle_cnt_o)
    , .retire_cnt_o  (retire_cnt_o)
`endif
  );

  typedef struct {
    logic        ready, rsp, mem, halt, lready, lrsp;
    logic [31:0] inst;
    logic [6:0]  exp_o;
    logic [31:0] exp_inst;
  } vec_t;

  typedef struct {
    logic [6:0]  o;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic ready, rsp, mem, halt, lready, lrsp,
                              input logic [31:0] inst, input logic [6:0] eo,
                              input logic [31:0] ei);
    vec_t v;
    v.ready = ready; v.rsp = rsp; v.mem = mem; v.halt = halt;
    v.lready = lready; v.lrsp = lrsp; v.inst = inst;
    v.exp_o = eo; v.exp_inst = ei;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {ifu_req_valid_o, lsu_req_valid_o, pc_we_o, rf_we_en_o, busy_o, halted_o, err_o};
  endfunction

  task automatic check_now(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, outs=%b", tag, outs());
      return;
    end
    e = exp_q.pop_front();
    if (outs() !== e.o || inst_o !== e.inst) begin
      failures++;
      $display("FAIL %s: outs=%b inst=%h required outs=%b inst=%h (valid,lsu,pc_we,rf_we,busy,halted,err) t=%0t",
               tag, outs(), inst_o, e.o, e.inst, $time);
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", tag, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    ifu_req_ready_i = v.ready;
    ifu_rsp_valid_i = v.rsp;
    mem_access_i    = v.mem;
    halt_i          = v.halt;
    lsu_req_ready_i = v.lready;
    lsu_rsp_valid_i = v.lrsp;
    inst_i          = v.inst;
  endtask

  // Row semantics: outputs expected in the cycle after the next edge, inputs
  // held during that same cycle.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk); #1;
    drive(v);
    e.o = v.exp_o; e.inst = v.exp_inst;
    exp_q.push_back(e);
    @(negedge clk);
    check_now(tag);
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, '0, '0, '0));
    @(posedge clk); @(posedge clk); #1;
    e.o = O_IDLE; e.inst = NOP;
    exp_q.push_back(e);
    check_now("reset");
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pc_seen;
    exp_t e;

    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, I1, O_FREQ, (k == 0) ? NOP : I1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, I1, O_WAIT, (k == 0) ? NOP : I1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, I1, O_EXEC, I1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, I1, O_WB,   I1));
    end
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, I1, O_FREQ, I1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I1, O_FREQ, I1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I1, O_WAIT, I1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, I2, O_WAIT, I1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, I2, O_EXEC, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_MREQ, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_MREQ, I2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, I2, O_MREQ, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_WAIT, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_WAIT, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, I2, O_WAIT, I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_WB,   I2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, I2, O_FREQ, I2));

    do_reset();
    foreach (tbl[i]) step(tbl[i], $sformatf("table[%0d]", i));

    // halt_i outranks mem_access_i, and HALT is absorbing.
    do_reset();
    step(mk(1, 0, 0, 0, 0, 0, I3, O_FREQ, NOP), "halt_freq");
    step(mk(0, 1, 0, 0, 0, 0, I3, O_WAIT, NOP), "halt_fwait");
    step(mk(0, 0, 1, 1, 0, 0, I3, O_EXEC, I3), "halt_exec");
    pc_seen = 0;
    for (int k = 0; k < 100; k++) begin
      step(mk(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom, O_HALT, I3), $sformatf("halted[%0d]", k));
      if (pc_we_o || lsu_req_valid_o) pc_seen++;
    end
    check_val("halt_no_writes", 64'(pc_seen), 64'd0);

    // No response for the full eight cycles of FETCH_WAIT.
    do_reset();
    step(mk(1, 0, 0, 0, 0, 0, I1, O_FREQ, NOP), "to_freq");
    for (int k = 0; k < 8; k++)
      step(mk(0, 0, 0, 0, 0, 0, I1, O_WAIT, NOP), $sformatf("to_wait[%0d]", k));
    step(mk(0, 0, 0, 0, 0, 0, I1, O_HERR, NOP), "to_halt_err");
    step(mk(1, 1, 0, 0, 0, 0, I1, O_HERR, NOP), "to_err_sticky");

    // Response on the eighth waiting cycle is a success.
    do_reset();
    step(mk(1, 0, 0, 0, 0, 0, I1, O_FREQ, NOP), "late_freq");
    for (int k = 0; k < 7; k++)
      step(mk(0, 0, 0, 0, 0, 0, I1, O_WAIT, NOP), $sformatf("late_wait[%0d]", k));
    step(mk(0, 1, 0, 0, 0, 0, I2, O_WAIT, NOP), "late_rsp");
    step(mk(0, 0, 0, 0, 0, 0, I2, O_EXEC, I2), "late_exec");
    step(mk(0, 0, 0, 0, 0, 0, I2, O_WB, I2), "late_wb");

    // Asynchronous reset in MEM_WAIT, observed with no clock edge in between.
    do_reset();
    step(mk(1, 0, 0, 0, 0, 0, I2, O_FREQ, NOP), "ar_freq");
    step(mk(0, 1, 0, 0, 0, 0, I2, O_WAIT, NOP), "ar_fwait");
    step(mk(0, 0, 1, 0, 0, 0, I2, O_EXEC, I2), "ar_exec");
    step(mk(0, 0, 0, 0, 1, 0, I2, O_MREQ, I2), "ar_mreq");
    step(mk(0, 0, 0, 0, 0, 0, I2, O_WAIT, I2), "ar_mwait");
    #1 rst = 1'b0;
    #1;
    e.o = O_IDLE; e.inst = NOP;
    exp_q.push_back(e);
    check_now("async_reset");

`ifdef STAGE_CTRL_PERF_CNT_EN
    check_val("retire_after_reset", retire_cnt_o, 64'd0);
    check_val("cycle_after_reset", cycle_cnt_o, 64'd0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 1, 0, 0, 0, 0, I1, O_FREQ, (k == 0) ? NOP : I1), "perf_freq");
      step(mk(1, 1, 0, 0, 0, 0, I1, O_WAIT, (k == 0) ? NOP : I1), "perf_fwait");
      step(mk(0, 0, 0, 0, 0, 0, I1, O_EXEC, I1), "perf_exec");
      step(mk(0, 0, 0, 0, 0, 0, I1, O_WB, I1), "perf_wb");
    end
    step(mk(0, 0, 0, 0, 0, 0, I1, O_FREQ, I1), "perf_after");
    check_val("retire_three", retire_cnt_o, 64'd3);
    check_val("cycle_thirteen", cycle_cnt_o, 64'd13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
